// File: rtl/lms_weight_update_if.sv
// Bundle between the LMS error stage and the weight-update block:
// error/sample inputs, control strobes and the weight feedback path.
interface lms_weight_update_if #(
   parameter int NUM_EL = 4,
   parameter int CNT_W  = 16
);
   logic                   adapt_en;
   logic                   w_clear;
   logic                   in_valid;
   logic [17:0]            econj_i;
   logic [17:0]            econj_q;
   logic [18*NUM_EL-1:0]   x_i;
   logic [18*NUM_EL-1:0]   x_q;
   logic [18*NUM_EL-1:0]   w_i;
   logic [18*NUM_EL-1:0]   w_q;
   logic                   w_valid;
   logic [CNT_W-1:0]       upd_cnt;
   logic                   sat_flag;

   modport master (
      output adapt_en, w_clear, in_valid, econj_i, econj_q, x_i, x_q,
      input  w_i, w_q, w_valid, upd_cnt, sat_flag
   );

   modport slave (
      input  adapt_en, w_clear, in_valid, econj_i, econj_q, x_i, x_q,
      output w_i, w_q, w_valid, upd_cnt, sat_flag
   );
endinterface

// File: rtl/lms_weight_update.sv
// Complex LMS weight update w_k += 2^-MU_SHIFT * x_k * conj(e), Q2.16 weights.
// Two stages: product capture, then round/shift and saturating accumulate.
module lms_weight_update #(
   parameter int NUM_EL   = 4,
   parameter int MU_SHIFT = 4,
   parameter int CNT_W    = 16
) (
   input logic                clk,
   input logic                rst_n,
   lms_weight_update_if.slave bus
);
   localparam int DATA_W = 18;
   localparam int PROD_W = 37;
   localparam int ACC_W  = 40;
   localparam int SHIFT  = 16 + MU_SHIFT;
   localparam logic signed [DATA_W-1:0] ONE     = 18'sd65536;
   localparam logic signed [DATA_W-1:0] SAT_MAX = 18'h1FFFF;
   localparam logic signed [DATA_W-1:0] SAT_MIN = 18'h20000;
   localparam logic signed [ACC_W-1:0]  LIM_HI  = ACC_W'(131071);
   localparam logic signed [ACC_W-1:0]  LIM_LO  = -LIM_HI - ACC_W'(1);

   function automatic logic signed [PROD_W-1:0] sext_p(input logic [DATA_W-1:0] v);
      return {{(PROD_W-DATA_W){v[DATA_W-1]}}, v};
   endfunction

   function automatic logic signed [ACC_W-1:0] sext_w(input logic signed [DATA_W-1:0] v);
      return {{(ACC_W-DATA_W){v[DATA_W-1]}}, v};
   endfunction

   // Round half up: add half an output LSB, then arithmetic shift.
   function automatic logic signed [ACC_W-1:0] round_shift(input logic signed [PROD_W-1:0] p);
      logic signed [ACC_W-1:0] t;
      t = {{(ACC_W-PROD_W){p[PROD_W-1]}}, p} + (ACC_W'(1) << (SHIFT - 1));
      return t >>> SHIFT;
   endfunction

   function automatic logic sat_hit(input logic signed [ACC_W-1:0] v);
      return (v > LIM_HI) || (v < LIM_LO);
   endfunction

   function automatic logic signed [DATA_W-1:0] sat18(input logic signed [ACC_W-1:0] v);
      if (v > LIM_HI)      return SAT_MAX;
      else if (v < LIM_LO) return SAT_MIN;
      else                 return v[DATA_W-1:0];
   endfunction

   logic signed [PROD_W-1:0] pr_c  [NUM_EL];
   logic signed [PROD_W-1:0] pi_c  [NUM_EL];
   logic signed [PROD_W-1:0] pr_p1 [NUM_EL];
   logic signed [PROD_W-1:0] pi_p1 [NUM_EL];
   logic                     vld_p1;
   logic signed [PROD_W-1:0] ei_x, eq_x, xi_x, xq_x;

   logic signed [DATA_W-1:0] w_re     [NUM_EL];
   logic signed [DATA_W-1:0] w_im     [NUM_EL];
   logic signed [DATA_W-1:0] w_re_nxt [NUM_EL];
   logic signed [DATA_W-1:0] w_im_nxt [NUM_EL];
   logic signed [ACC_W-1:0]  sum_re, sum_im;
   logic                     sat_nxt;

   // Stage 0: x_k * conj(e) products (error arrives already conjugated)
   always_comb begin
      ei_x = sext_p(bus.econj_i);
      eq_x = sext_p(bus.econj_q);
      xi_x = '0;
      xq_x = '0;
      for (int k = 0; k < NUM_EL; k++) begin
         xi_x    = sext_p(bus.x_i[DATA_W*k +: DATA_W]);
         xq_x    = sext_p(bus.x_q[DATA_W*k +: DATA_W]);
         pr_c[k] = xi_x * ei_x - xq_x * eq_x;
         pi_c[k] = xi_x * eq_x + xq_x * ei_x;
      end
   end

   always_ff @(posedge clk) begin
      if (bus.in_valid && bus.adapt_en) begin
         pr_p1 <= pr_c;
         pi_p1 <= pi_c;
      end
   end

   // Stage 1: scale by mu, accumulate with saturation
   always_comb begin
      sat_nxt = 1'b0;
      sum_re  = '0;
      sum_im  = '0;
      for (int k = 0; k < NUM_EL; k++) begin
         sum_re      = sext_w(w_re[k]) + round_shift(pr_p1[k]);
         sum_im      = sext_w(w_im[k]) + round_shift(pi_p1[k]);
         w_re_nxt[k] = sat18(sum_re);
         w_im_nxt[k] = sat18(sum_im);
         sat_nxt     = sat_nxt | sat_hit(sum_re) | sat_hit(sum_im);
      end
   end

   // w_clear shares the reset path so it overrides any in-flight update.
   always_ff @(posedge clk) begin
      if (!rst_n || bus.w_clear) begin
         vld_p1       <= 1'b0;
         bus.w_valid  <= 1'b0;
         bus.upd_cnt  <= '0;
         bus.sat_flag <= 1'b0;
         for (int k = 0; k < NUM_EL; k++) begin
            w_re[k] <= (k == 0) ? ONE : '0;
            w_im[k] <= '0;
         end
      end else begin
         vld_p1      <= bus.in_valid & bus.adapt_en;
         bus.w_valid <= vld_p1;
         if (vld_p1) begin
            w_re        <= w_re_nxt;
            w_im        <= w_im_nxt;
            bus.upd_cnt <= bus.upd_cnt + CNT_W'(1);
            if (sat_nxt) bus.sat_flag <= 1'b1;
         end
      end
   end

   always_comb begin
      bus.w_i = '0;
      bus.w_q = '0;
      for (int k = 0; k < NUM_EL; k++) begin
         bus.w_i[DATA_W*k +: DATA_W] = w_re[k];
         bus.w_q[DATA_W*k +: DATA_W] = w_im[k];
      end
   end
endmodule
